mux_uart_tx: RTL



---
 rtl/mux_uart_tx.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mux_uart_tx.sv
// -----------------------------------------------------------------------------
// mux_uart_tx
//
// Bus-attached transmit-only UART for diagnostic MUX channel 0. CPU writes to
// the data register (BASE_ADDR+1) are queued in a small FIFO and sent as 8N1
// frames on tx. A CPU read of BASE_ADDR returns the status byte that the ROM
// polls before each write.
//
// Status byte: bit1 = FIFO not full, bit3 = idle (FIFO empty and no frame in
// progress), bit7 = sticky overflow. All other bits are zero. A write of any
// value to BASE_ADDR clears overflow.
//
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   synchronous, active-high
//   address  in   [18:0] CPU address bus
//   write_en in   CPU write strobe
//   data_in  in   [7:0] CPU write data
//   data_out out  [7:0] read data, combinational from address
//   sel      out  address hits the status or the data register
//   tx       out  serial output, idle high
//   busy     out  FIFO non-empty or a frame in progress
//
// Optional build macro MUX_UART_TRACE_EN: prints each accepted byte (masked
// to 7 bits, printable / TAB / LF / CR only) to the simulation console. It
// adds no hardware.
// -----------------------------------------------------------------------------
module mux_uart_tx #(
    parameter logic [18:0] BASE_ADDR    = 19'h3f200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          FIFO_AW      = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        tx,
    output logic        busy
);

    localparam logic [18:0]      DATA_ADDR   = BASE_ADDR + 19'd1;
    localparam int               TW          = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]    TIMER_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] COUNT_ONE   = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [FIFO_AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [FIFO_AW:0]   count_reg, count_next;
    logic               overflow_reg, overflow_next;

    // Transmitter
    state_t             state_reg, state_next;
    logic [TW-1:0]      timer_reg, timer_next;
    logic [2:0]         bit_idx_reg, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_reg, tx_next;

    logic stat_hit, data_hit;
    logic fifo_full, fifo_empty;
    logic push, pop;
    logic tx_idle;
    logic [7:0] status;

    // -------------------------------------------------------------------------
    // Bus decode and status
    // -------------------------------------------------------------------------
    assign stat_hit   = (address == BASE_ADDR);
    assign data_hit   = (address == DATA_ADDR);
    assign fifo_full  = (count_reg == DEPTH_COUNT);
    assign fifo_empty = (count_reg == '0);
    assign tx_idle    = fifo_empty && (state_reg == IDLE);

    // Full is judged on the count before this edge, so a pop on the same edge
    // does not make room for the byte.
    assign push = write_en && data_hit && !fifo_full;

    assign status   = {overflow_reg, 3'b000, tx_idle, 1'b0, !fifo_full, 1'b0};
    assign data_out = stat_hit ? status : 8'h00;
    assign sel      = stat_hit || data_hit;
    assign tx       = tx_reg;
    assign busy     = !tx_idle;

    // -------------------------------------------------------------------------
    // FIFO bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        // Pointers are exactly FIFO_AW bits wide, so they wrap on their own.
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_ONE;
            2'b01:   count_next = count_reg - COUNT_ONE;
            default: count_next = count_reg;
        endcase

        if (write_en && data_hit && fifo_full) begin
            overflow_next = 1'b1;
        end else if (write_en && stat_hit) begin
            overflow_next = 1'b0;
        end
    end

    // Storage has no reset so it maps onto distributed/block RAM; the read
    // side is registered through shift_reg.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_in;
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr_reg];
                    timer_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (timer_reg == TIMER_LAST) begin
                    timer_next   = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (timer_reg == TIMER_LAST) begin
                    timer_next = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                if (timer_reg == TIMER_LAST) begin
                    timer_next = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr_reg];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Line level is registered from the next state, so tx changes on the
        // same edge as the state and carries no decode glitches.
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            state_reg    <= IDLE;
            timer_reg    <= '0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            tx_reg       <= 1'b1;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
        end
    end

`ifdef MUX_UART_TRACE_EN
    // Console echo of accepted bytes, matching the system bench's UART hook.
    task automatic trace_char(input logic [7:0] value);
        logic [7:0] ch;
        ch = value & 8'h7f;
        if (ch >= 8'd32 || ch == 8'd9 || ch == 8'd10 || ch == 8'd13) begin
            $write("%c", ch);
        end
    endtask

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            trace_char(data_in);
        end
    end
`endif

endmodule
